// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - shared widths and request/response structs for the OBI memory responder
// Purpose: common types for the responder top and its response pipe.
//   obi_req_t : one initiator request (byte address, active-low write enable, write data)
//   obi_rsp_t : one response beat (valid flag, read data)
package obi_pkg;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;

  typedef struct packed {
    logic [OBI_ADDR_W-1:0] addr;
    logic                  web;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  valid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_rsp_t;

endpackage

// File: rtl/obi_resp_pipe.sv
// rtl/obi_resp_pipe.sv - fixed-latency shift register carrying responses
// Purpose: delays every response beat by LATENCY clock edges; sync clear drops all beats.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high clear of every stage
//   in_rsp     in   beat entering stage 0 (valid=0 beats carry rdata=0)
//   out_rsp    out  beat held in the last stage
//   last_load  out  a valid beat moves into the last stage on the coming edge
module obi_resp_pipe
  import obi_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  obi_rsp_t in_rsp,
  output obi_rsp_t out_rsp,
  output logic     last_load
);

  obi_rsp_t stage [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= in_rsp;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_rsp = stage[LATENCY-1];

  generate
    if (LATENCY == 1) begin : g_lat1
      assign last_load = in_rsp.valid;
    end else begin : g_latn
      assign last_load = stage[LATENCY-2].valid;
    end
  endgenerate

endmodule

// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - OBI-style memory responder with fixed-latency in-order responses
// Purpose: word-addressed RAM behind a request/grant link; each accepted request returns
//   exactly one single-cycle valid pulse LATENCY cycles later, in accept order.
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-high reset (RAM contents kept)
//   proc_req  in   1   initiator request
//   addr      in   32  byte address, bits [1:0] ignored, upper bits alias
//   web       in   1   0 = write, 1 = read
//   wdata     in   32  write data
//   stall     in   1   forces mem_rdy low while high
//   mem_rdy   out  1   grant; accept = proc_req & mem_rdy at a rising edge
//   rdata     out  32  read data (0 for writes and whenever valid is low)
//   valid     out  1   one-cycle response pulse per accepted request
module obi_mem_responder
  import obi_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  proc_req,
  input  logic [OBI_ADDR_W-1:0] addr,
  input  logic                  web,
  input  logic [OBI_DATA_W-1:0] wdata,
  input  logic                  stall,
  output logic                  mem_rdy,
  output logic [OBI_DATA_W-1:0] rdata,
  output logic                  valid
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  obi_req_t              req;
  obi_rsp_t              rsp_in;
  obi_rsp_t              rsp_out;
  logic [IDX_W-1:0]      idx;
  logic                  accept;
  logic                  last_load;
  logic [CNT_W-1:0]      outstanding;
  logic [OBI_DATA_W-1:0] mem [MEM_WORDS];
  logic                  unused_addr_bits;

  assign req = '{addr: addr, web: web, wdata: wdata};
  assign idx = req.addr[IDX_W+1:2];
  assign unused_addr_bits = ^{req.addr[OBI_ADDR_W-1:IDX_W+2], req.addr[1:0]};

  // Grant depends only on the count, never on proc_req, so there is no req->rdy path.
  assign mem_rdy = !rst && !stall && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign accept  = proc_req && mem_rdy;

  always_ff @(posedge clk) begin
    if (accept && !req.web) begin
      mem[idx] <= req.wdata;
    end
  end

  // Read data is taken before this edge's write lands; a write answers with zero.
  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = accept;
    if (accept && req.web) begin
      rsp_in.rdata = mem[idx];
    end
  end

  obi_resp_pipe #(
    .LATENCY(LATENCY)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_rsp   (rsp_in),
    .out_rsp  (rsp_out),
    .last_load(last_load)
  );

  assign valid = rsp_out.valid;
  assign rdata = rsp_out.rdata;

  // A request stops counting on the edge its response enters the output register, so the
  // cycle presenting a response may already grant a new one; with MAX_OUTSTANDING equal to
  // LATENCY this sustains an accept every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, last_load})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(last_load && !accept && outstanding == '0))
        else $error("outstanding counter underflow");
      assert (outstanding <= CNT_W'(MAX_OUTSTANDING))
        else $error("outstanding counter above limit");
    end
  end

endmodule
